// File: rtl/sm_timer_pkg.sv
// sm_timer_pkg: opcodes, host FSM states and command-word packing for the 64-bit stopwatch timer link
package sm_timer_pkg;
  localparam logic [15:0] OP_START = 16'd1;
  localparam logic [15:0] OP_STOP  = 16'd2;
  localparam logic [15:0] OP_RESET = 16'd3;
  localparam logic [15:0] OP_READ  = 16'd4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESP
  } host_state_e;
  function automatic logic [31:0] make_cmd(input logic [2:0] op);
    return {13'b0, op, 16'h0000};
  endfunction
endpackage

// File: rtl/sm_timer_64_host.sv
// sm_timer_64_host: issues START/STOP/RESET/READ command beats and assembles the two-beat READ return
module sm_timer_64_host
  import sm_timer_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  output logic        mCMD_tvalid,
  input  logic        mCMD_tready,
  output logic [31:0] mCMD_tdata,
  input  logic        sRet_tvalid,
  output logic        sRet_tready,
  input  logic [31:0] sRet_tdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_time,
  output logic [63:0] rsp_delta,
  output logic        rsp_timeout,
  output logic        busy
);
  host_state_e state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] prev_q, prev_d, time_q, time_d, delta_q, delta_d;
  logic        to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic        op_legal, to_hit;
  logic [63:0] full_time;
  assign op_legal    = req_op >= 3'd1 && req_op <= 3'd4;
  assign to_hit      = TIMEOUT != 0 && cnt_q == TO_W'(TIMEOUT - 1);
  assign full_time   = {sRet_tdata, lo_q};
  assign req_ready   = state_q == S_IDLE;
  assign mCMD_tvalid = state_q == S_SEND;
  assign sRet_tready = state_q == S_WAIT_LO || state_q == S_WAIT_HI;
  assign rsp_valid   = state_q == S_RESP;
  assign busy        = state_q != S_IDLE;
  assign mCMD_tdata  = make_cmd(op_q);
  assign rsp_time    = time_q;
  assign rsp_delta   = delta_q;
  assign rsp_timeout = to_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lo_d    = lo_q;
    prev_d  = prev_q;
    time_d  = time_q;
    delta_d = delta_q;
    to_d    = to_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && op_legal) begin
          op_d    = req_op;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (mCMD_tready) begin
          state_d = op_q == 3'(OP_READ) ? S_WAIT_LO : S_IDLE;
          prev_d  = op_q == 3'(OP_RESET) ? '0 : prev_q;
        end
      end
      S_WAIT_LO, S_WAIT_HI: begin
        if (sRet_tvalid && state_q == S_WAIT_LO) begin
          lo_d    = sRet_tdata;
          state_d = S_WAIT_HI;
        end else if (sRet_tvalid) begin
          time_d  = full_time;
          delta_d = full_time - prev_q;
          prev_d  = full_time;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (to_hit) begin
          // abort: report a zero timestamp and leave prev_time for the next good read
          time_d  = '0;
          delta_d = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      lo_q    <= '0;
      prev_q  <= '0;
      time_q  <= '0;
      delta_q <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      prev_q  <= prev_d;
      time_q  <= time_d;
      delta_q <= delta_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sm_timer_64_host.sv
// tb_sm_timer_64_host: scoreboard bench; expected command words and READ results are queued at stimulus time
module tb_sm_timer_64_host;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic        mCMD_tvalid, mCMD_tready = 1'b1;
  logic [31:0] mCMD_tdata;
  logic        sRet_tvalid = 1'b0, sRet_tready;
  logic [31:0] sRet_tdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [63:0] rsp_time, rsp_delta;
  logic        rsp_timeout, busy;
  typedef struct packed {
    logic [63:0] t;
    logic [63:0] d;
    logic        to;
  } rsp_t;
  logic [31:0] exp_cmd[$];
  rsp_t        exp_rsp[$];
  int n_cmp = 0, n_err = 0;
  sm_timer_64_host #(.TIMEOUT(8), .TO_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .mCMD_tvalid(mCMD_tvalid), .mCMD_tready(mCMD_tready), .mCMD_tdata(mCMD_tdata),
    .sRet_tvalid(sRet_tvalid), .sRet_tready(sRet_tready), .sRet_tdata(sRet_tdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_time(rsp_time),
    .rsp_delta(rsp_delta), .rsp_timeout(rsp_timeout), .busy(busy)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  // handshakes complete on the next posedge, so sampling at negedge sees them
  always @(negedge ACLK) begin
    if (!ARESET && mCMD_tvalid && mCMD_tready) begin
      chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
      if (exp_cmd.size() != 0) chk("cmd_word", 64'(mCMD_tdata), 64'(exp_cmd.pop_front()));
    end
    if (!ARESET && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
      if (exp_rsp.size() != 0) begin
        chk("rsp_time", rsp_time, exp_rsp[0].t);
        chk("rsp_delta", rsp_delta, exp_rsp[0].d);
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_rsp[0].to));
        void'(exp_rsp.pop_front());
      end
    end
  end
  task automatic do_req(input logic [2:0] op, input logic [31:0] cmd, input bit legal);
    if (legal) exp_cmd.push_back(cmd);
    req_valid = 1'b1;
    req_op    = op;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask
  task automatic do_ret(input logic [31:0] data);
    sRet_tvalid = 1'b1;
    sRet_tdata  = data;
    for (int i = 0; i < 20 && !sRet_tready; i++) tick();
    chk("ret_ready_wait", 64'(sRet_tready), 64'd1);
    tick();
    sRet_tvalid = 1'b0;
  endtask
  task automatic get_rsp(input int hold);
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk("rsp_hold_time", rsp_time, exp_rsp[0].t);
      chk("rsp_hold_delta", rsp_delta, exp_rsp[0].d);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic do_read(input logic [63:0] t, input logic [63:0] d, input int hold);
    exp_rsp.push_back('{t: t, d: d, to: 1'b0});
    do_req(3'd4, 32'h0004_0000, 1'b1);
    do_ret(t[31:0]);
    do_ret(t[63:32]);
    get_rsp(hold);
  endtask
  initial begin
    int n;
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_cmd_valid", 64'(mCMD_tvalid), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_time", rsp_time, 64'd0);
    ARESET = 1'b0;
    tick();
    mCMD_tready = 1'b0;
    do_req(3'd1, 32'h0001_0000, 1'b1);
    chk("send_valid", 64'(mCMD_tvalid), 64'd1);
    #2 ARESET = 1'b1;
    #1 chk("async_drop", 64'(mCMD_tvalid), 64'd0);
    exp_cmd.delete();
    tick();
    ARESET = 1'b0;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    do_req(3'd1, 32'h0001_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("start_hold_data", 64'(mCMD_tdata), 64'h0001_0000);
      chk("start_hold_valid", 64'(mCMD_tvalid), 64'd1);
      tick();
    end
    chk("start_hold_data", 64'(mCMD_tdata), 64'h0001_0000);
    mCMD_tready = 1'b1;
    tick();
    chk("start_idle", 64'(busy), 64'd0);
    tick();
    chk("start_no_rsp", 64'(rsp_valid), 64'd0);
    do_read(64'h2_0000_0010, 64'h2_0000_0010, 0);
    do_read(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFD_FFFF_FFE0, 0);
    do_read(64'h10, 64'h20, 5);
    exp_rsp.push_back('{t: 64'd0, d: 64'd0, to: 1'b1});
    do_req(3'd4, 32'h0004_0000, 1'b1);
    tick();
    chk("wait_lo_ready", 64'(sRet_tready), 64'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd8);
    get_rsp(0);
    do_read(64'h30, 64'h20, 0);
    do_req(3'd2, 32'h0002_0000, 1'b1);
    tick();
    do_req(3'd7, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("illegal_no_cmd", 64'(mCMD_tvalid), 64'd0);
      chk("illegal_not_busy", 64'(busy), 64'd0);
      tick();
    end
    do_req(3'd3, 32'h0003_0000, 1'b1);
    tick();
    do_read(64'h5_0000_0005, 64'h5_0000_0005, 0);
    tick();
    chk("cmd_q_drained", 64'(exp_cmd.size()), 64'd0);
    chk("rsp_q_drained", 64'(exp_rsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
